horner_eval: RTL and testbench

- Polynomial evaluator sitting directly downstream of the 11-entry coefficient mux.
- Drives the mux's coeff_select and consumes its registered coeff output to compute y = sum c_k * x^k (k = 0..NCOEF-1) by Horner's rule in signed fixed point.
- Uses a srdyi/srdyo start/done handshake so that it can be chained into the rest of the datapath.

---
 rtl/horner_eval.sv | 84 ++++++++
 tb/tb_horner_eval.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/horner_eval.sv
// horner_eval: Horner's-rule polynomial evaluator that drives an external coefficient mux, using signed fixed point with saturation.
module horner_eval #(
    parameter int NCOEF   = 11,
    parameter int WIDTH   = 32,
    parameter int FRAC    = 16,
    parameter int MUX_LAT = 1
) (
    input  logic             Clock,
    input  logic             GlobalReset,
    input  logic             srdyi_i,
    input  logic [WIDTH-1:0] x_i,
    input  logic [WIDTH-1:0] coeff,
    output logic [3:0]       coeff_select,
    output logic             busy_o,
    output logic [WIDTH-1:0] y_o,
    output logic             srdyo_o,
    output logic             ovf_o
);
    localparam int FIRST = MUX_LAT + 1;
    localparam int LAST  = NCOEF + MUX_LAT;
    localparam int CW    = $clog2(LAST + 1);
    localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
    typedef enum logic {IDLE, RUN} state_t;
    state_t state;
    logic [CW-1:0] step;
    logic [WIDTH-1:0] acc, x_r;
    logic ovf_r;
    logic signed [2*WIDTH-1:0] prod, shifted;
    logic [WIDTH-1:0] scaled, nxt;
    logic [WIDTH:0] sum;
    logic sat_m, sat_a;
    // Product is kept at full width so the shift sees every bit before saturation.
    always_comb begin
        prod    = $signed({{WIDTH{acc[WIDTH-1]}}, acc}) * $signed({{WIDTH{x_r[WIDTH-1]}}, x_r});
        shifted = prod >>> FRAC;
        sat_m   = !(&shifted[2*WIDTH-1:WIDTH-1] || ~|shifted[2*WIDTH-1:WIDTH-1]);
        scaled  = sat_m ? (shifted[2*WIDTH-1] ? SMIN : SMAX) : shifted[WIDTH-1:0];
        sum     = {scaled[WIDTH-1], scaled} + {coeff[WIDTH-1], coeff};
        sat_a   = sum[WIDTH] != sum[WIDTH-1];
        nxt     = sat_a ? (sum[WIDTH] ? SMIN : SMAX) : sum[WIDTH-1:0];
    end
    always_ff @(posedge Clock) begin
        if (GlobalReset) begin
            state        <= IDLE;
            step         <= '0;
            acc          <= '0;
            x_r          <= '0;
            ovf_r        <= 1'b0;
            coeff_select <= '0;
            busy_o       <= 1'b0;
            y_o          <= '0;
            srdyo_o      <= 1'b0;
            ovf_o        <= 1'b0;
        end else begin
            srdyo_o <= 1'b0;
            if (state == IDLE) begin
                if (srdyi_i) begin
                    x_r          <= x_i;
                    coeff_select <= 4'(NCOEF - 1);
                    step         <= CW'(1);
                    ovf_r        <= 1'b0;
                    busy_o       <= 1'b1;
                    state        <= RUN;
                end
            end else begin
                coeff_select <= (coeff_select == 4'd0) ? 4'd0 : coeff_select - 4'd1;
                step         <= step + CW'(1);
                // step numbers the current edge relative to acceptance (edge 0).
                if (step >= CW'(FIRST)) begin
                    acc   <= (step == CW'(FIRST)) ? coeff : nxt;
                    ovf_r <= ovf_r | ((step > CW'(FIRST)) & (sat_m | sat_a));
                end
                if (step == CW'(LAST)) begin
                    y_o     <= nxt;
                    ovf_o   <= ovf_r | sat_m | sat_a;
                    srdyo_o <= 1'b1;
                    busy_o  <= 1'b0;
                    state   <= IDLE;
                end
            end
        end
    end
endmodule

// File: tb/tb_horner_eval.sv
// tb_horner_eval: directed tests of horner_eval against a c_k = k<<16 coefficient mux with one cycle of latency.
module tb_horner_eval;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        srdyi = 1'b0;
    logic [31:0] x = '0;
    logic [31:0] coeff = '0;
    logic [3:0]  coeff_select;
    logic        busy, srdyo, ovf;
    logic [31:0] y;
    int n_cmp = 0;
    int n_bad = 0;
    horner_eval dut (
        .Clock(clk), .GlobalReset(rst), .srdyi_i(srdyi), .x_i(x), .coeff(coeff),
        .coeff_select(coeff_select), .busy_o(busy), .y_o(y), .srdyo_o(srdyo), .ovf_o(ovf)
    );
    always #5 clk = ~clk;
    always_ff @(posedge clk) coeff <= {12'd0, coeff_select, 16'd0};
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic eval(input logic [31:0] xv, output int lat);
        srdyi = 1'b1;
        x = xv;
        tick();
        srdyi = 1'b0;
        x = 32'hDEAD_BEEF;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!srdyo && lat < 40);
    endtask
    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_cmp += 5;
        if (coeff_select !== 4'd0) begin n_bad++; $display("FAIL reset_cs got %0d want 0", coeff_select); end
        if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
        if (y !== 32'd0) begin n_bad++; $display("FAIL reset_y got %h want 0", y); end
        if (srdyo !== 1'b0) begin n_bad++; $display("FAIL reset_srdyo got %b want 0", srdyo); end
        if (ovf !== 1'b0) begin n_bad++; $display("FAIL reset_ovf got %b want 0", ovf); end
        rst = 1'b0;
        tick();
    endtask
    task automatic test_eval();
        logic [31:0] xs [4] = '{32'h0001_0000, 32'hFFFF_0000, 32'h0002_0000, 32'h0004_0000};
        logic [31:0] ys [4] = '{32'h0037_0000, 32'h0005_0000, 32'h4802_0000, 32'h7FFF_FFFF};
        logic        os [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        int lat;
        for (int i = 0; i < 4; i++) begin
            eval(xs[i], lat);
            n_cmp += 3;
            if (lat != 12) begin n_bad++; $display("FAIL eval%0d_latency got %0d want 12", i, lat); end
            if (y !== ys[i]) begin n_bad++; $display("FAIL eval%0d_y got %h want %h", i, y, ys[i]); end
            if (ovf !== os[i]) begin n_bad++; $display("FAIL eval%0d_ovf got %b want %b", i, ovf, os[i]); end
            tick();
        end
    endtask
    task automatic test_coeff_select();
        int pulses = 0;
        srdyi = 1'b1;
        x = 32'h0001_0000;
        tick();
        srdyi = 1'b0;
        for (int i = 0; i <= 10; i++) begin
            n_cmp += 2;
            if (coeff_select !== 4'(10 - i)) begin n_bad++; $display("FAIL cs_seq%0d got %0d want %0d", i, coeff_select, 10 - i); end
            if (busy !== 1'b1) begin n_bad++; $display("FAIL cs_busy%0d got %b want 1", i, busy); end
            srdyi = (i % 3 == 1);
            x = 32'h0004_0000;
            tick();
            pulses += int'(srdyo);
        end
        srdyi = 1'b0;
        for (int i = 0; i < 12; i++) begin
            pulses += int'(srdyo);
            if (srdyo) begin
                n_cmp++;
                if (y !== 32'h0037_0000) begin n_bad++; $display("FAIL ignore_y got %h want 00370000", y); end
            end
            tick();
        end
        n_cmp++;
        if (pulses != 1) begin n_bad++; $display("FAIL ignore_pulses got %0d want 1", pulses); end
    endtask
    task automatic test_back_to_back();
        int lat, gap;
        eval(32'h0002_0000, lat);
        srdyi = 1'b1;
        x = 32'h0001_0000;
        n_cmp += 2;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL b2b_busy_done got %b want 0", busy); end
        if (y !== 32'h4802_0000) begin n_bad++; $display("FAIL b2b_y1 got %h want 48020000", y); end
        gap = 0;
        do begin
            tick();
            gap++;
            if (gap == 1) begin
                n_cmp++;
                if (busy !== 1'b1) begin n_bad++; $display("FAIL b2b_restart got %b want 1", busy); end
            end
        end while (!srdyo && gap < 40);
        srdyi = 1'b0;
        n_cmp += 2;
        if (gap != 13) begin n_bad++; $display("FAIL b2b_gap got %0d want 13", gap); end
        if (y !== 32'h0037_0000) begin n_bad++; $display("FAIL b2b_y2 got %h want 00370000", y); end
        for (int i = 0; i < 15; i++) tick();
    endtask
    task automatic test_reset_abort();
        int pulses = 0;
        int lat;
        srdyi = 1'b1;
        x = 32'h0001_0000;
        tick();
        srdyi = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp += 3;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy got %b want 0", busy); end
        if (y !== 32'd0) begin n_bad++; $display("FAIL abort_y got %h want 0", y); end
        if (coeff_select !== 4'd0) begin n_bad++; $display("FAIL abort_cs got %0d want 0", coeff_select); end
        for (int i = 0; i < 15; i++) begin
            pulses += int'(srdyo);
            tick();
        end
        n_cmp++;
        if (pulses != 0) begin n_bad++; $display("FAIL abort_pulses got %0d want 0", pulses); end
        eval(32'h0001_0000, lat);
        n_cmp += 2;
        if (lat != 12) begin n_bad++; $display("FAIL after_abort_latency got %0d want 12", lat); end
        if (y !== 32'h0037_0000) begin n_bad++; $display("FAIL after_abort_y got %h want 00370000", y); end
    endtask
    initial begin
        test_reset();
        test_eval();
        test_coeff_select();
        test_back_to_back();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
